// File: rtl/alu_shift_pipe.sv
// Two-stage pipelined shift/rotate unit with valid/ready flow control and
// per-thread flush. S1 captures the operation, S2 computes and registers the
// result bus and COASZP flags.
module alu_shift_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 6,
    parameter int unsigned THR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             except,
    input  logic [THR_W-1:0] except_thread,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_sz64,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [THR_W-1:0] in_thread,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_res,
    output logic [5:0]       out_flags,
    output logic             out_flags_en,
    output logic [THR_W-1:0] out_thread
);

    localparam logic [3:0] OpShl  = 4'd0;
    localparam logic [3:0] OpShr  = 4'd1;
    localparam logic [3:0] OpSar  = 4'd2;
    localparam logic [3:0] OpRol  = 4'd3;
    localparam logic [3:0] OpRor  = 4'd4;
    localparam logic [3:0] OpRcl  = 4'd5;
    localparam logic [3:0] OpRcr  = 4'd6;
    localparam logic [3:0] OpShld = 4'd7;
    localparam logic [3:0] OpShrd = 4'd8;

    // S1 registers
    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic             s1_sz64_q;
    logic             s1_cin_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [CNT_W-1:0] s1_cnt_q;
    logic [THR_W-1:0] s1_thread_q;

    logic s1_load, s2_load;
    logic flush_in, flush_s1, flush_s2;

    // Compute-stage intermediates; operands carry one spare bit so the
    // rotate-through-carry value {C,a} fits for full-width ops.
    logic [CNT_W:0]        n_w, c_ext, n_minus_c, n1_minus_c, c_minus1;
    logic [WIDTH:0]        mask_n, mask_n1, a_m, b_m, v, r_x, res_x;
    logic signed [WIDTH-1:0] sext;
    logic [WIDTH-1:0]      sar_r, res;
    logic                  cy, ov, rsvd, msb_r, msb2_r, msb_a;
    logic [5:0]            flags_d;
    logic                  flags_en_d;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;

    assign flush_in = except & (in_thread == except_thread);
    assign flush_s1 = except & (s1_thread_q == except_thread);
    assign flush_s2 = except & (out_thread == except_thread);

    // S1 capture: load when advancing, otherwise hold unless flushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_sz64_q   <= 1'b0;
            s1_cin_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cnt_q    <= '0;
            s1_thread_q <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid & ~flush_in;
            if (in_valid) begin
                s1_op_q     <= in_op;
                s1_sz64_q   <= in_sz64;
                s1_cin_q    <= in_cin;
                s1_a_q      <= in_a;
                s1_b_q      <= in_b;
                s1_cnt_q    <= in_cnt & (in_sz64 ? CNT_W'(WIDTH - 1) : CNT_W'(31));
                s1_thread_q <= in_thread;
            end
        end else begin
            s1_valid_q <= s1_valid_q & ~flush_s1;
        end
    end

    // S2 combinational shift/rotate and flag evaluation from S1 contents
    always_comb begin
        n_w        = s1_sz64_q ? (CNT_W+1)'(WIDTH) : (CNT_W+1)'(32);
        c_ext      = {1'b0, s1_cnt_q};
        n_minus_c  = n_w - c_ext;
        n1_minus_c = n_w + (CNT_W+1)'(1) - c_ext;
        c_minus1   = c_ext - (CNT_W+1)'(1);
        mask_n     = s1_sz64_q ? {1'b0, {WIDTH{1'b1}}} : (WIDTH+1)'(33'h0_FFFF_FFFF);
        mask_n1    = (mask_n << 1) | (WIDTH+1)'(1);
        a_m        = {1'b0, s1_a_q} & mask_n;
        b_m        = {1'b0, s1_b_q} & mask_n;
        v          = a_m;
        v[n_w]     = s1_cin_q;
        sext       = s1_sz64_q ? s1_a_q : WIDTH'($signed(s1_a_q[31:0]));
        sar_r      = sext >>> s1_cnt_q;
        rsvd       = (s1_op_q > OpShrd);
        r_x        = '0;
        res_x      = '0;
        cy         = 1'b0;

        case (s1_op_q)
            OpShl: begin
                res_x = a_m << s1_cnt_q;
                cy    = a_m[n_minus_c];
            end
            OpShr: begin
                res_x = a_m >> s1_cnt_q;
                cy    = a_m[c_minus1];
            end
            OpSar: begin
                res_x = {1'b0, sar_r};
                cy    = a_m[c_minus1];
            end
            OpRol: begin
                res_x = (a_m << s1_cnt_q) | (a_m >> n_minus_c);
                cy    = a_m[n_minus_c];
            end
            OpRor: begin
                res_x = (a_m >> s1_cnt_q) | (a_m << n_minus_c);
                cy    = a_m[c_minus1];
            end
            OpRcl: begin
                r_x   = ((v << s1_cnt_q) | (v >> n1_minus_c)) & mask_n1;
                res_x = r_x;
                cy    = r_x[n_w];
            end
            OpRcr: begin
                r_x   = ((v >> s1_cnt_q) | (v << n1_minus_c)) & mask_n1;
                res_x = r_x;
                cy    = r_x[n_w];
            end
            OpShld: begin
                res_x = (a_m << s1_cnt_q) | (b_m >> n_minus_c);
                cy    = a_m[n_minus_c];
            end
            OpShrd: begin
                res_x = (a_m >> s1_cnt_q) | (b_m << n_minus_c);
                cy    = a_m[c_minus1];
            end
            default: ;
        endcase

        res = WIDTH'(res_x & mask_n);
        // Zero count passes the operand through and leaves flags untouched
        if (s1_cnt_q == '0) begin
            res = WIDTH'(a_m);
            cy  = s1_cin_q;
        end
        if (rsvd) begin
            res = '0;
        end

        msb_r  = s1_sz64_q ? res[WIDTH-1] : res[31];
        msb2_r = s1_sz64_q ? res[WIDTH-2] : res[30];
        msb_a  = s1_sz64_q ? s1_a_q[WIDTH-1] : s1_a_q[31];

        ov = 1'b0;
        if (s1_cnt_q == CNT_W'(1)) begin
            case (s1_op_q)
                OpShl, OpRol, OpRcl, OpShld: ov = cy ^ msb_r;
                OpShr, OpShrd:               ov = msb_a;
                OpRor, OpRcr:                ov = msb_r ^ msb2_r;
                default:                     ov = 1'b0;
            endcase
        end

        flags_d    = rsvd ? 6'b0 : {cy, ov, 1'b0, msb_r, ~|res, ~^res[7:0]};
        flags_en_d = ~rsvd & (s1_cnt_q != '0);
    end

    // S2 output register: holds under backpressure, cleared by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_res      <= '0;
            out_flags    <= '0;
            out_flags_en <= 1'b0;
            out_thread   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid_q & ~flush_s1;
            if (s1_valid_q) begin
                out_res      <= {^res, 1'b0, res};
                out_flags    <= flags_d;
                out_flags_en <= flags_en_d;
                out_thread   <= s1_thread_q;
            end
        end else begin
            out_valid <= out_valid & ~flush_s2;
        end
    end

endmodule
